// File: rtl/sram_ahb_pkg.sv
// Shared AHB-Lite encodings and phase-slot records for the SRAM-side AHB initiator.
package sram_ahb_pkg;

  localparam int AHB_ADDR_W = 8;
  localparam int AHB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef struct packed {
    logic                  valid;
    logic                  write;
    logic [2:0]            size;
    logic [AHB_ADDR_W-1:0] addr;
    logic [AHB_DATA_W-1:0] wdata;
  } addr_phase_t;

  // wdata here is what sits on hwdata during the data phase
  typedef struct packed {
    logic                  valid;
    logic                  write;
    logic [AHB_DATA_W-1:0] wdata;
  } data_phase_t;

  // The slave port is at most 32 bits wide, so larger sizes fold to a word
  function automatic logic [2:0] clamp_size(input logic [2:0] size);
    return (size > HSIZE_WORD) ? HSIZE_WORD : size;
  endfunction

endpackage

// File: rtl/sram_controller_ahb_master_wdog.sv
// Data-phase watchdog: counts consecutive stalled cycles and raises a sticky flag
// once the limit is reached. Built only with SRAM_AHB_MASTER_TIMEOUT_EN.
module sram_controller_ahb_master_wdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic srst,
  input  logic stall_i,
  input  logic hready_i,
  output logic timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    if (hready_i) begin
      count_d = '0;
    end else if (stall_i && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
    if (count_d == CNT_MAX) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign timeout_o = err_q;

endmodule

// File: rtl/sram_controller_ahb_master.sv
// AHB-Lite initiator: valid/ready commands become single NONSEQ transfers, one in-order
// response each. Optional data-phase watchdog under SRAM_AHB_MASTER_TIMEOUT_EN.
module sram_controller_ahb_master
  import sram_ahb_pkg::*;
#(
  parameter int ADDR_W         = AHB_ADDR_W,
  parameter int DATA_W         = AHB_DATA_W,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              hsel,
  output logic [ADDR_W-1:0] haddr,
  output logic              hwrite,
  output logic [1:0]        htrans,
  output logic [2:0]        hsize,
  output logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hrdata,
  input  logic              hready,
  input  logic              hresp,
  output logic              busy,
  output logic              timeout_err
);

  addr_phase_t a_q, a_d;
  data_phase_t d_q, d_d;

  logic              rsp_valid_q, rsp_write_q, rsp_err_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              accept;
  logic              complete;

  assign cmd_ready = !a_q.valid || hready;
  assign accept    = cmd_valid && cmd_ready;
  assign complete  = d_q.valid && hready;

  // An empty address slot may be filled even while the data phase is stalled
  always_comb begin
    a_d = a_q;
    d_d = d_q;
    if (hready) begin
      d_d.valid = a_q.valid;
      d_d.write = a_q.write;
      if (a_q.valid && a_q.write) begin
        d_d.wdata = a_q.wdata;
      end
      a_d.valid = 1'b0;
    end
    if (accept) begin
      a_d.valid = 1'b1;
      a_d.write = cmd_write;
      a_d.size  = clamp_size(cmd_size);
      a_d.addr  = cmd_addr;
      a_d.wdata = cmd_wdata;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      a_q <= '0;
      d_q <= '0;
    end else begin
      a_q <= a_d;
      d_q <= d_d;
    end
  end

  // rsp_rdata keeps the last read value across write completions
  always_ff @(posedge hclk) begin
    if (hreset) begin
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= complete;
      if (complete) begin
        rsp_write_q <= d_q.write;
        rsp_err_q   <= hresp;
        if (!d_q.write) begin
          rsp_rdata_q <= hrdata;
        end
      end
    end
  end

  assign hsel      = a_q.valid;
  assign htrans    = a_q.valid ? NONSEQ : IDLE;
  assign haddr     = a_q.addr;
  assign hwrite    = a_q.write;
  assign hsize     = a_q.size;
  assign hwdata    = d_q.wdata;
  assign busy      = a_q.valid || d_q.valid;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

`ifdef SRAM_AHB_MASTER_TIMEOUT_EN
  sram_controller_ahb_master_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk      (hclk),
    .srst     (hreset),
    .stall_i  (d_q.valid && !hready),
    .hready_i (hready),
    .timeout_o(timeout_err)
  );
`else
  assign timeout_err = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

endmodule
